// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared state, memory-command and instruction encodings for cpu_control
package cpu_defs;

    typedef enum logic [4:0] {
        S_RST,
        S_IF1,
        S_IF2,
        S_UPC,
        S_DEC,
        S_WRIMM,
        S_GETA,
        S_GETB,
        S_EXEC,
        S_WRC,
        S_ADDR,
        S_LDADR,
        S_MRD1,
        S_MRD2,
        S_EXEC2,
        S_MWR,
        S_HALT
    } state_e;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // {opcode, op} pairs the dispatch understands; everything else halts
    localparam logic [4:0] INS_MOV_IMM = {OPC_MOV, 2'b10};
    localparam logic [4:0] INS_MOV_REG = {OPC_MOV, 2'b00};
    localparam logic [4:0] INS_ADD     = {OPC_ALU, 2'b00};
    localparam logic [4:0] INS_CMP     = {OPC_ALU, 2'b01};
    localparam logic [4:0] INS_AND     = {OPC_ALU, 2'b10};
    localparam logic [4:0] INS_MVN     = {OPC_ALU, 2'b11};
    localparam logic [4:0] INS_LDR     = {OPC_LDR, 2'b00};
    localparam logic [4:0] INS_STR     = {OPC_STR, 2'b00};

    localparam logic [1:0] VSEL_C     = 2'd0;
    localparam logic [1:0] VSEL_PC    = 2'd1;
    localparam logic [1:0] VSEL_IMM   = 2'd2;
    localparam logic [1:0] VSEL_MDATA = 2'd3;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_MVN = 2'b11;

    typedef struct packed {
        logic [1:0] mem_cmd;
        logic [1:0] vsel;
        logic [2:0] writenum;
        logic [2:0] readnum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] alu_op;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational field split and immediate sign extension of the instruction register
module instr_decoder
    import cpu_defs::*;
#(
    parameter int IW = 16
) (
    input  logic [IW-1:0] ir,
    output logic [2:0]    opcode,
    output logic [1:0]    op,
    output logic [2:0]    rn,
    output logic [2:0]    rd,
    output logic [2:0]    rm,
    output logic [1:0]    shift,
    output logic [IW-1:0] sximm5,
    output logic [IW-1:0] sximm8
);

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];
    assign sximm5 = {{(IW-5){ir[4]}}, ir[4:0]};
    assign sximm8 = {{(IW-8){ir[7]}}, ir[7:0]};

    // memory ops reuse ir[4:3] as offset bits, so the shifter must stay idle
    always_comb begin
        shift = ir[4:3];
        if (opcode == OPC_LDR || opcode == OPC_STR) begin
            shift = 2'b00;
        end
    end

endmodule

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - fetch/decode Moore FSM driving datapath controls and memory commands
module cpu_control
    import cpu_defs::*;
#(
    parameter int PCW = 9,
    parameter int IW  = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [IW-1:0]  mem_rdata,
    input  logic [IW-1:0]  datapath_out,
    output logic [1:0]     mem_cmd,
    output logic [PCW-1:0] mem_addr,
    output logic [1:0]     vsel,
    output logic [2:0]     writenum,
    output logic [2:0]     readnum,
    output logic           write,
    output logic           loada,
    output logic           loadb,
    output logic           loadc,
    output logic           loads,
    output logic           asel,
    output logic           bsel,
    output logic [1:0]     shift,
    output logic [1:0]     ALUop,
    output logic [IW-1:0]  sximm5,
    output logic [IW-1:0]  sximm8,
    output logic [7:0]     pc_out,
    output logic           halted
);

    state_e         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [PCW-1:0] da_q, da_d;
    logic [IW-1:0]  ir_q, ir_d;
    ctrl_t          ctrl_q, ctrl_d;
    logic [PCW-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]     shift_q;
    logic [IW-1:0]  sximm5_q, sximm8_q;

    logic [2:0]     dec_opcode, dec_rn, dec_rd, dec_rm;
    logic [1:0]     dec_op, dec_shift;
    logic [IW-1:0]  dec_sximm5, dec_sximm8;
    logic [4:0]     dec_ins;
    logic           unused_dp_hi;

    assign unused_dp_hi = ^datapath_out[IW-1:PCW];

    // Decoding ir_d lets the registered outputs line up with the state they belong to;
    // outside S_IF2 ir_d equals ir_q, so dispatch sees the held instruction.
    instr_decoder #(.IW(IW)) u_dec (
        .ir     (ir_d),
        .opcode (dec_opcode),
        .op     (dec_op),
        .rn     (dec_rn),
        .rd     (dec_rd),
        .rm     (dec_rm),
        .shift  (dec_shift),
        .sximm5 (dec_sximm5),
        .sximm8 (dec_sximm8)
    );

    assign dec_ins = {dec_opcode, dec_op};

    // instruction register captures the fetched word in the second fetch cycle
    always_comb begin
        ir_d = ir_q;
        if (state_q == S_IF2) begin
            ir_d = mem_rdata;
        end
    end

    // next state, pc increment and data-address capture
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        da_d    = da_q;
        case (state_q)
            S_RST:   state_d = S_IF1;
            S_IF1:   state_d = S_IF2;
            S_IF2:   state_d = S_UPC;
            S_UPC: begin
                pc_d    = pc_q + 1'b1;
                state_d = S_DEC;
            end
            S_DEC: begin
                case (dec_ins)
                    INS_MOV_IMM:                      state_d = S_WRIMM;
                    INS_MOV_REG, INS_MVN:             state_d = S_GETB;
                    INS_ADD, INS_AND, INS_CMP,
                    INS_LDR, INS_STR:                 state_d = S_GETA;
                    default:                          state_d = S_HALT;
                endcase
            end
            S_WRIMM: state_d = S_IF1;
            S_GETA:  state_d = (dec_ins == INS_LDR || dec_ins == INS_STR) ? S_ADDR : S_GETB;
            S_GETB:  state_d = (dec_ins == INS_STR) ? S_EXEC2 : S_EXEC;
            S_EXEC:  state_d = (dec_ins == INS_CMP) ? S_IF1 : S_WRC;
            S_WRC:   state_d = S_IF1;
            S_ADDR:  state_d = S_LDADR;
            S_LDADR: begin
                da_d    = datapath_out[PCW-1:0];
                state_d = (dec_ins == INS_LDR) ? S_MRD1 : S_GETB;
            end
            S_MRD1:  state_d = S_MRD2;
            S_MRD2:  state_d = S_IF1;
            S_EXEC2: state_d = S_MWR;
            S_MWR:   state_d = S_IF1;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // Moore output decode for the state being entered, registered below
    always_comb begin
        ctrl_d     = '0;
        mem_addr_d = '0;
        case (state_d)
            S_IF1, S_IF2: begin
                ctrl_d.mem_cmd = MEM_READ;
                mem_addr_d     = pc_d;
            end
            S_WRIMM: begin
                ctrl_d.vsel     = VSEL_IMM;
                ctrl_d.writenum = dec_rn;
                ctrl_d.write    = 1'b1;
            end
            S_GETA: begin
                ctrl_d.readnum = dec_rn;
                ctrl_d.loada   = 1'b1;
            end
            S_GETB: begin
                ctrl_d.readnum = (dec_ins == INS_STR) ? dec_rd : dec_rm;
                ctrl_d.loadb   = 1'b1;
            end
            S_EXEC: begin
                case (dec_ins)
                    INS_MOV_REG: begin
                        ctrl_d.asel   = 1'b1;
                        ctrl_d.alu_op = ALU_ADD;
                        ctrl_d.loadc  = 1'b1;
                    end
                    INS_CMP: begin
                        ctrl_d.alu_op = ALU_CMP;
                        ctrl_d.loads  = 1'b1;
                    end
                    INS_MVN: begin
                        ctrl_d.asel   = 1'b1;
                        ctrl_d.alu_op = ALU_MVN;
                        ctrl_d.loadc  = 1'b1;
                    end
                    default: begin
                        ctrl_d.alu_op = dec_op;
                        ctrl_d.loadc  = 1'b1;
                    end
                endcase
            end
            S_WRC: begin
                ctrl_d.vsel     = VSEL_C;
                ctrl_d.writenum = dec_rd;
                ctrl_d.write    = 1'b1;
            end
            S_ADDR: begin
                ctrl_d.bsel  = 1'b1;
                ctrl_d.loadc = 1'b1;
            end
            S_MRD1: begin
                ctrl_d.mem_cmd = MEM_READ;
                mem_addr_d     = da_d;
            end
            S_MRD2: begin
                ctrl_d.mem_cmd  = MEM_READ;
                mem_addr_d      = da_d;
                ctrl_d.vsel     = VSEL_MDATA;
                ctrl_d.writenum = dec_rd;
                ctrl_d.write    = 1'b1;
            end
            S_EXEC2: begin
                ctrl_d.asel  = 1'b1;
                ctrl_d.loadc = 1'b1;
            end
            S_MWR: begin
                ctrl_d.mem_cmd = MEM_WRITE;
                mem_addr_d     = da_d;
            end
            S_HALT:  ctrl_d.halted = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    // state, architectural registers and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_RST;
            pc_q       <= '0;
            da_q       <= '0;
            ir_q       <= '0;
            ctrl_q     <= '0;
            mem_addr_q <= '0;
            shift_q    <= '0;
            sximm5_q   <= '0;
            sximm8_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            da_q       <= da_d;
            ir_q       <= ir_d;
            ctrl_q     <= ctrl_d;
            mem_addr_q <= mem_addr_d;
            shift_q    <= dec_shift;
            sximm5_q   <= dec_sximm5;
            sximm8_q   <= dec_sximm8;
        end
    end

    assign mem_cmd  = ctrl_q.mem_cmd;
    assign mem_addr = mem_addr_q;
    assign vsel     = ctrl_q.vsel;
    assign writenum = ctrl_q.writenum;
    assign readnum  = ctrl_q.readnum;
    assign write    = ctrl_q.write;
    assign loada    = ctrl_q.loada;
    assign loadb    = ctrl_q.loadb;
    assign loadc    = ctrl_q.loadc;
    assign loads    = ctrl_q.loads;
    assign asel     = ctrl_q.asel;
    assign bsel     = ctrl_q.bsel;
    assign ALUop    = ctrl_q.alu_op;
    assign halted   = ctrl_q.halted;
    assign shift    = shift_q;
    assign sximm5   = sximm5_q;
    assign sximm8   = sximm8_q;
    assign pc_out   = 8'(pc_q);

endmodule

// File: tb/tb_cpu_control.sv
// tb/tb_cpu_control.sv - directed-vector bench for cpu_control
module tb_cpu_control;

    logic        clk;
    logic        reset_n;
    logic [15:0] mem_rdata;
    logic [15:0] datapath_out;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [1:0]  vsel;
    logic [2:0]  writenum, readnum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  shift, ALUop;
    logic [15:0] sximm5, sximm8;
    logic [7:0]  pc_out;
    logic        halted;

    logic [15:0] mem [0:511];

    int vectors;
    int miscompares;

    cpu_control #(.PCW(9), .IW(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_rdata    (mem_rdata),
        .datapath_out (datapath_out),
        .mem_cmd      (mem_cmd),
        .mem_addr     (mem_addr),
        .vsel         (vsel),
        .writenum     (writenum),
        .readnum      (readnum),
        .write        (write),
        .loada        (loada),
        .loadb        (loadb),
        .loadc        (loadc),
        .loads        (loads),
        .asel         (asel),
        .bsel         (bsel),
        .shift        (shift),
        .ALUop        (ALUop),
        .sximm5       (sximm5),
        .sximm8       (sximm8),
        .pc_out       (pc_out),
        .halted       (halted)
    );

    assign mem_rdata = mem[mem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // strobe order: {write, loada, loadb, loadc, loads, asel, bsel}
    task automatic cyc(input string tag, input logic [1:0] cmd, input logic [8:0] addr,
                       input logic [6:0] strb);
        check({tag, ".cmd"}, 32'(mem_cmd), 32'(cmd));
        check({tag, ".addr"}, 32'(mem_addr), 32'(addr));
        check({tag, ".strb"}, 32'({write, loada, loadb, loadc, loads, asel, bsel}), 32'(strb));
        @(negedge clk);
    endtask

    task automatic fetch(input string tag, input logic [8:0] pc);
        cyc({tag, ".if1"}, 2'b01, pc, 7'b0000000);
        cyc({tag, ".if2"}, 2'b01, pc, 7'b0000000);
        cyc({tag, ".upc"}, 2'b00, 9'd0, 7'b0000000);
        check({tag, ".pc_out"}, 32'(pc_out), 32'(pc + 9'd1));
        cyc({tag, ".dec"}, 2'b00, 9'd0, 7'b0000000);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        datapath_out = 16'h0000;
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[0] = 16'hD007;  // MOV R0,#7
        mem[1] = 16'hA140;  // ADD R2,R1,R0
        mem[2] = 16'hA800;  // CMP R0,R0
        mem[3] = 16'h6061;  // LDR R3,[R0,#1]
        mem[4] = 16'h8062;  // STR R3,[R0,#2]
        mem[5] = 16'hE000;  // HALT
        mem[8] = 16'h1234;

        reset_n = 1'b0;
        @(negedge clk);
        check("rst.cmd", 32'(mem_cmd), 32'd0);
        check("rst.addr", 32'(mem_addr), 32'd0);
        check("rst.pc", 32'(pc_out), 32'd0);
        check("rst.halted", 32'(halted), 32'd0);
        check("rst.strb", 32'({write, loada, loadb, loadc, loads, asel, bsel}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // MOV R0,#7
        fetch("mov", 9'd0);
        check("mov.vsel", 32'(vsel), 32'd2);
        check("mov.wnum", 32'(writenum), 32'd0);
        check("mov.imm8", 32'(sximm8), 32'h0007);
        check("mov.pc", 32'(pc_out), 32'd1);
        cyc("mov.wrimm", 2'b00, 9'd0, 7'b1000000);

        // ADD R2,R1,R0
        fetch("add", 9'd1);
        check("add.geta.rn", 32'(readnum), 32'd1);
        cyc("add.geta", 2'b00, 9'd0, 7'b0100000);
        check("add.getb.rm", 32'(readnum), 32'd0);
        cyc("add.getb", 2'b00, 9'd0, 7'b0010000);
        check("add.exec.alu", 32'(ALUop), 32'd0);
        cyc("add.exec", 2'b00, 9'd0, 7'b0001000);
        check("add.wrc.wnum", 32'(writenum), 32'd2);
        check("add.wrc.vsel", 32'(vsel), 32'd0);
        cyc("add.wrc", 2'b00, 9'd0, 7'b1000000);

        // CMP R0,R0
        fetch("cmp", 9'd2);
        cyc("cmp.geta", 2'b00, 9'd0, 7'b0100000);
        cyc("cmp.getb", 2'b00, 9'd0, 7'b0010000);
        check("cmp.exec.alu", 32'(ALUop), 32'd1);
        cyc("cmp.exec", 2'b00, 9'd0, 7'b0000100);

        // LDR R3,[R0,#1]
        datapath_out = 16'h0008;
        fetch("ldr", 9'd3);
        cyc("ldr.geta", 2'b00, 9'd0, 7'b0100000);
        check("ldr.imm5", 32'(sximm5), 32'h0001);
        check("ldr.shift", 32'(shift), 32'd0);
        check("ldr.addr.alu", 32'(ALUop), 32'd0);
        cyc("ldr.addr", 2'b00, 9'd0, 7'b0001001);
        cyc("ldr.ldadr", 2'b00, 9'd0, 7'b0000000);
        cyc("ldr.mrd1", 2'b01, 9'd8, 7'b0000000);
        check("ldr.mrd2.vsel", 32'(vsel), 32'd3);
        check("ldr.mrd2.wnum", 32'(writenum), 32'd3);
        cyc("ldr.mrd2", 2'b01, 9'd8, 7'b1000000);

        // STR R3,[R0,#2]
        datapath_out = 16'h0009;
        fetch("str", 9'd4);
        cyc("str.geta", 2'b00, 9'd0, 7'b0100000);
        cyc("str.addr", 2'b00, 9'd0, 7'b0001001);
        cyc("str.ldadr", 2'b00, 9'd0, 7'b0000000);
        check("str.getb.rd", 32'(readnum), 32'd3);
        cyc("str.getb", 2'b00, 9'd0, 7'b0010000);
        cyc("str.exec2", 2'b00, 9'd0, 7'b0001010);
        cyc("str.mwr", 2'b10, 9'd9, 7'b0000000);

        // HALT absorbs until reset
        fetch("halt", 9'd5);
        for (int i = 0; i < 20; i++) begin
            check("halt.halted", 32'(halted), 32'd1);
            cyc("halt.idle", 2'b00, 9'd0, 7'b0000000);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("hrst.pc", 32'(pc_out), 32'd0);
        check("hrst.halted", 32'(halted), 32'd0);
        cyc("hrst.rst", 2'b00, 9'd0, 7'b0000000);

        // reset in the middle of ADD
        fetch("mov2", 9'd0);
        cyc("mov2.wrimm", 2'b00, 9'd0, 7'b1000000);
        fetch("add2", 9'd1);
        cyc("add2.geta", 2'b00, 9'd0, 7'b0100000);
        cyc("add2.getb", 2'b00, 9'd0, 7'b0010000);
        check("add2.exec.loadc", 32'(loadc), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mrst.pc", 32'(pc_out), 32'd0);
        cyc("mrst.rst", 2'b00, 9'd0, 7'b0000000);
        cyc("mrst.if1", 2'b01, 9'd0, 7'b0000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
